// File: rtl/frame_packer_pkg.sv
// Shared types and header packing for the frame packer.
package frame_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_TRAILER
  } state_e;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5A5;
  localparam int unsigned HDR_CNT_W         = 16;

  function automatic logic [31:0] pack_header(input logic [15:0] sync,
                                              input logic [HDR_CNT_W-1:0] cnt);
    return {sync, cnt};
  endfunction

endpackage

// File: rtl/frame_packer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_ok, rd_ok;

  assign wr_ok = wr_en_i && (count_q != CW'(DEPTH));
  assign rd_ok = rd_en_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/frame_packer.sv
// Groups buffered words into header / payload / XOR-trailer frames on a valid/ready stream.
module frame_packer
  import frame_packer_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 16,
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [15:0] frame_cnt,
  output logic        overflow,
  input  logic        clr_ovf
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(PAYLOAD_LEN + 1);

  state_e               state_q, state_d;
  logic [31:0]          m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic [31:0]          chk_q, chk_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [HDR_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                 overflow_q, overflow_d;

  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count, buf_count;
  logic          full, wr_en, drop, pop, load, have_frame;

  // The payload word sitting in the output register still counts as buffered
  // until its handshake, so occupancy matches pop-on-handshake semantics.
  assign buf_count  = fifo_count + {{(CW-1){1'b0}}, state_q == ST_PAYLOAD};
  assign full       = buf_count >= CW'(FIFO_DEPTH);
  assign wr_en      = din_valid && !full;
  assign drop       = din_valid && full;
  assign have_frame = buf_count >= CW'(PAYLOAD_LEN);
  assign load       = !m_valid_q || m_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (din),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    chk_d       = chk_q;
    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    pop         = 1'b0;
    overflow_d  = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);

    // Outside IDLE, m_valid is high, so load implies a handshake.
    if (load) begin
      unique case (state_q)
        ST_IDLE: begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (have_frame) begin
            state_d   = ST_HEADER;
            m_data_d  = pack_header(SYNC_WORD, frame_cnt_q);
            m_valid_d = 1'b1;
          end
        end
        ST_HEADER: begin
          state_d  = ST_PAYLOAD;
          m_data_d = fifo_head;
          chk_d    = chk_q ^ fifo_head;
          beat_d   = BW'(1);
          pop      = 1'b1;
        end
        ST_PAYLOAD: begin
          if (beat_q == BW'(PAYLOAD_LEN)) begin
            state_d  = ST_TRAILER;
            m_data_d = chk_q;
            m_last_d = 1'b1;
          end else begin
            m_data_d = fifo_head;
            chk_d    = chk_q ^ fifo_head;
            beat_d   = beat_q + BW'(1);
            pop      = 1'b1;
          end
        end
        ST_TRAILER: begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          chk_d       = '0;
          m_last_d    = 1'b0;
          if (have_frame) begin
            state_d  = ST_HEADER;
            m_data_d = pack_header(SYNC_WORD, frame_cnt_d);
          end else begin
            state_d   = ST_IDLE;
            m_data_d  = '0;
            m_valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      chk_q       <= '0;
      beat_q      <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      chk_q       <= chk_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;

endmodule
